// File: rtl/run_ctrl.sv
// run_ctrl -- run/step/pause/halt sequencer for a pipelined core.
//
// Decides, cycle by cycle, whether the pipeline advances (state=1, "exec")
// or holds (state=0). Supports free running, single stepping, pausing,
// a single PC breakpoint and a HALT opcode seen at writeback.
//
// Ports
//   clock      in   1   system clock, all state updates on rising edge
//   reset      in   1   asynchronous active-low reset
//   start      in   1   level request to run continuously
//   stop       in   1   level request to pause
//   step       in   1   single-step request, acted on at its rising edge
//   wb_ir      in   16  writeback instruction, opcode in [15:11]
//   i_addr     in   8   current fetch PC
//   bp_en      in   1   breakpoint enable
//   bp_addr    in   8   breakpoint PC
//   state      out  1   pipeline enable (combinational)
//   run_state  out  3   FSM state: IDLE=0 RUN=1 STEP=2 PAUSE=3 HALTED=4
//   cycle_cnt  out  16  number of exec cycles, wraps at 16'hFFFF
//   bp_hit     out  1   sticky: the last pause was caused by a breakpoint
//
// Control inputs are plain levels (no valid/ready handshake): start/stop are
// sampled every rising edge, step only contributes on its 0->1 transition.

module run_ctrl #(
  parameter logic [4:0] HALT_OPC = 5'h1F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic [15:0] wb_ir,
  input  logic [7:0]  i_addr,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  output logic        state,
  output logic [2:0]  run_state,
  output logic [15:0] cycle_cnt,
  output logic        bp_hit
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_PAUSE  = 3'd3,
    S_HALTED = 3'd4
  } run_state_e;

  run_state_e  state_q, state_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic        bp_hit_q, bp_hit_d;
  logic        bp_skip_q, bp_skip_d;
  logic        step_q;            // step delayed one cycle, for edge detect

  logic        step_pulse;
  logic        halt_op;
  logic        bp_match;
  logic        exec;
  logic        cnt_clr;
  logic        bp_hit_set;
  logic        leave_pause;
  logic        unused_ir;

  assign unused_ir  = ^wb_ir[10:0];
  assign step_pulse = step & ~step_q;
  assign halt_op    = (wb_ir[15:11] == HALT_OPC);

  // bp_skip masks the match for the first exec cycle after a resume, so the
  // instruction sitting at the breakpoint PC is allowed to issue once.
  assign bp_match = (state_q == S_RUN) & bp_en & (i_addr == bp_addr) & ~bp_skip_q;
  assign exec     = (state_q == S_STEP) | ((state_q == S_RUN) & ~bp_match);

  // State register (all sequential state).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= 16'h0000;
      bp_hit_q    <= 1'b0;
      bp_skip_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bp_hit_q    <= bp_hit_d;
      bp_skip_q   <= bp_skip_d;
      step_q      <= step;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    bp_hit_set  = 1'b0;
    leave_pause = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous step pulse.
        if (start) begin
          state_d = S_RUN;
          cnt_clr = 1'b1;
        end else if (step_pulse) begin
          state_d = S_STEP;
          cnt_clr = 1'b1;
        end
      end
      S_RUN: begin
        // HALT beats stop, stop beats breakpoint; step pulses are dropped.
        if (halt_op) begin
          state_d = S_HALTED;
        end else if (stop) begin
          state_d = S_PAUSE;
        end else if (bp_match) begin
          state_d    = S_PAUSE;
          bp_hit_set = 1'b1;
        end
      end
      S_STEP: begin
        if (halt_op) state_d = S_HALTED;
        else         state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (start) begin
          state_d     = S_RUN;
          leave_pause = 1'b1;
        end else if (step_pulse) begin
          state_d     = S_STEP;
          leave_pause = 1'b1;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    if (cnt_clr)   cycle_cnt_d = 16'h0000;
    else if (exec) cycle_cnt_d = cycle_cnt_q + 16'd1;
    else           cycle_cnt_d = cycle_cnt_q;

    if (leave_pause)     bp_hit_d = 1'b0;
    else if (bp_hit_set) bp_hit_d = 1'b1;
    else                 bp_hit_d = bp_hit_q;

    // exec is never 1 in PAUSE, so set and clear cannot collide.
    if (leave_pause) bp_skip_d = 1'b1;
    else if (exec)   bp_skip_d = 1'b0;
    else             bp_skip_d = bp_skip_q;
  end

  // Outputs.
  always_comb begin
    state     = exec;
    run_state = state_q;
    cycle_cnt = cycle_cnt_q;
    bp_hit    = bp_hit_q;
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- directed bench for run_ctrl.
// The driver applies one vector per clock (1 time unit after the rising edge)
// and pushes the hand-computed expected outputs for that cycle; the monitor
// pops and compares on every falling edge where an expectation is queued.
// Expected word layout: {run_state[2:0], state, cycle_cnt[15:0], bp_hit}.

module tb_run_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic        step;
  logic [15:0] wb_ir;
  logic [7:0]  i_addr;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic        state;
  logic [2:0]  run_state;
  logic [15:0] cycle_cnt;
  logic        bp_hit;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] HLT = 16'hF800;   // opcode 5'h1F

  logic [20:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          failures;
  logic        done;

  run_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .wb_ir     (wb_ir),
    .i_addr    (i_addr),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .state     (state),
    .run_state (run_state),
    .cycle_cnt (cycle_cnt),
    .bp_hit    (bp_hit)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cyc(input logic st, input logic sp, input logic stp,
                     input logic [15:0] ir, input logic [7:0] ia,
                     input logic chk, input logic [2:0] ers, input logic est,
                     input logic [15:0] ecnt, input logic ehit, input string nm);
    @(posedge clock);
    #1;
    start  = st;
    stop   = sp;
    step   = stp;
    wb_ir  = ir;
    i_addr = ia;
    if (chk) begin
      exp_q.push_back({ers, est, ecnt, ehit});
      name_q.push_back(nm);
    end
  endtask

  // Pulse reset low between clock edges; outputs are sampled on the falling
  // edge while reset is still low, i.e. before any rising edge can act.
  task automatic reset_pulse(input string nm);
    @(posedge clock);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    wb_ir = NOP;
    #1;
    reset = 1'b0;
    exp_q.push_back({3'd0, 1'b0, 16'h0000, 1'b0});
    name_q.push_back(nm);
    #5;
    reset = 1'b1;
  endtask

  // Stimulus
  initial begin
    done    = 1'b0;
    reset   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    step    = 1'b0;
    wb_ir   = NOP;
    i_addr  = 8'h00;
    bp_en   = 1'b0;
    bp_addr = 8'h00;
    #12;
    reset = 1'b1;

    // reset state, idle hold
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd0, 0, 16'd0, 0, "reset_idle");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd0, 0, 16'd0, 0, "idle_hold");

    // run 10 exec cycles, then stop
    cyc(1, 0, 0, NOP, 8'h00, 1, 3'd0, 0, 16'd0, 0, "start_req");
    for (int k = 0; k < 9; k++)
      cyc(1, 0, 0, NOP, 8'h00, 1, 3'd1, 1, 16'(k), 0, "run");
    cyc(0, 1, 0, NOP, 8'h00, 1, 3'd1, 1, 16'd9, 0, "run_stop");
    cyc(0, 1, 0, NOP, 8'h00, 1, 3'd3, 0, 16'd10, 0, "pause_hold");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd3, 0, 16'd10, 0, "paused");

    // step held high for 5 cycles -> one exec cycle
    cyc(0, 0, 1, NOP, 8'h00, 1, 3'd3, 0, 16'd10, 0, "step_req");
    cyc(0, 0, 1, NOP, 8'h00, 1, 3'd2, 1, 16'd10, 0, "step_exec");
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 1, NOP, 8'h00, 1, 3'd3, 0, 16'd11, 0, "step_held");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd3, 0, 16'd11, 0, "step_done");

    // breakpoint at 8'h05
    bp_en   = 1'b1;
    bp_addr = 8'h05;
    cyc(1, 0, 0, NOP, 8'h00, 1, 3'd3, 0, 16'd11, 0, "bp_start");
    for (int a = 1; a < 5; a++)
      cyc(1, 0, 0, NOP, 8'(a), 1, 3'd1, 1, 16'(10 + a), 0, "bp_run");
    cyc(0, 0, 0, NOP, 8'h05, 1, 3'd1, 0, 16'd15, 0, "bp_match");
    cyc(0, 0, 0, NOP, 8'h05, 1, 3'd3, 0, 16'd15, 1, "bp_paused");
    cyc(1, 0, 0, NOP, 8'h05, 1, 3'd3, 0, 16'd15, 1, "bp_resume_req");
    cyc(1, 0, 0, NOP, 8'h05, 1, 3'd1, 1, 16'd15, 0, "bp_skip_exec");
    cyc(1, 0, 0, NOP, 8'h06, 1, 3'd1, 1, 16'd16, 0, "bp_past");
    cyc(0, 0, 0, NOP, 8'h07, 1, 3'd1, 1, 16'd17, 0, "bp_past2");
    cyc(0, 1, 0, NOP, 8'h08, 1, 3'd1, 1, 16'd18, 0, "bp_stop");
    cyc(0, 0, 0, NOP, 8'h08, 1, 3'd3, 0, 16'd19, 0, "bp_stopped");
    bp_en = 1'b0;

    // asynchronous reset mid-RUN
    cyc(1, 0, 0, NOP, 8'h09, 1, 3'd3, 0, 16'd19, 0, "resume");
    cyc(1, 0, 0, NOP, 8'h0A, 1, 3'd1, 1, 16'd19, 0, "run_pre_rst");
    reset_pulse("async_rst");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd0, 0, 16'd0, 0, "post_rst_idle");

    // start+step together -> RUN; step pulse in RUN ignored; counter wrap
    cyc(1, 0, 1, NOP, 8'h00, 1, 3'd0, 0, 16'd0, 0, "start_step_idle");
    for (int k = 0; k < 65534; k++)
      cyc(1, 0, (k == 1), NOP, 8'h00, 0, 3'd0, 0, 16'd0, 0, "");
    cyc(1, 0, 0, NOP, 8'h00, 1, 3'd1, 1, 16'hFFFE, 0, "wrap_fffe");
    cyc(1, 0, 0, NOP, 8'h00, 1, 3'd1, 1, 16'hFFFF, 0, "wrap_ffff");
    cyc(0, 1, 0, NOP, 8'h00, 1, 3'd1, 1, 16'h0000, 0, "wrap_0000");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd3, 0, 16'h0001, 0, "wrap_0001");

    // HALT together with stop in RUN; HALTED ignores start/stop/step
    cyc(1, 0, 0, NOP, 8'h00, 1, 3'd3, 0, 16'd1, 0, "halt_resume_req");
    cyc(0, 1, 0, HLT, 8'h00, 1, 3'd1, 1, 16'd1, 0, "halt_stop_run");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd4, 0, 16'd2, 0, "halted");
    cyc(1, 0, 0, NOP, 8'h00, 1, 3'd4, 0, 16'd2, 0, "halted_start");
    cyc(0, 0, 1, NOP, 8'h00, 1, 3'd4, 0, 16'd2, 0, "halted_step");
    cyc(0, 1, 0, NOP, 8'h00, 1, 3'd4, 0, 16'd2, 0, "halted_stop");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd4, 0, 16'd2, 0, "halted_hold");
    reset_pulse("halt_rst");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd0, 0, 16'd0, 0, "post_halt_idle");

    // HALT seen during a single step
    cyc(0, 0, 1, NOP, 8'h00, 1, 3'd0, 0, 16'd0, 0, "step_req_idle");
    cyc(0, 0, 0, HLT, 8'h00, 1, 3'd2, 1, 16'd0, 0, "step_halt");
    cyc(0, 0, 0, NOP, 8'h00, 1, 3'd4, 0, 16'd1, 0, "step_halted");

    cyc(0, 0, 0, NOP, 8'h00, 0, 3'd0, 0, 16'd0, 0, "");
    cyc(0, 0, 0, NOP, 8'h00, 0, 3'd0, 0, 16'd0, 0, "");
    done = 1'b1;
  end

  // Scoreboard monitor and final report
  initial begin
    logic [20:0] exp;
    logic [20:0] act;
    string       nm;
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {run_state, state, cycle_cnt, bp_hit};
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL %s: got run_state=%0d state=%0b cycle_cnt=%h bp_hit=%0b, expected run_state=%0d state=%0b cycle_cnt=%h bp_hit=%0b",
                   nm, act[20:18], act[17], act[16:1], act[0],
                   exp[20:18], exp[17], exp[16:1], exp[0]);
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL queue_drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, level request to run continuously.
REQ-004 SHALL have port stop, input, 1, level request to pause.
REQ-005 SHALL have port step, input, 1, rising-edge request for one exec cycle.
REQ-006 SHALL have port wb_ir, input, 16, writeback-stage instruction; opcode in bits [15:11].
REQ-007 SHALL have port i_addr, input, 8, current fetch PC from IF.
REQ-008 SHALL have port bp_en, input, 1, breakpoint enable.
REQ-009 SHALL have port bp_addr, input, 8, breakpoint PC.
REQ-010 SHALL have port state, output, 1, pipeline enable to all stages; 1 = `exec`, 0 = idle.
REQ-011 SHALL have port run_state, output, 3, FSM encoding: IDLE=0, RUN=1, STEP=2, PAUSE=3, HALTED=4.
REQ-012 SHALL have port cycle_cnt, output, 16, count of cycles with state=1.
REQ-013 SHALL have port bp_hit, output, 1, sticky flag: a breakpoint caused the last pause.

Function
REQ-014 SHALL be a registered FSM with states IDLE, RUN, STEP, PAUSE, HALTED.
REQ-015 SHALL drive state combinationally: 1 in STEP; 1 in RUN unless a breakpoint match is active this cycle (REQ-020); 0 in every other case.
REQ-016 SHALL detect step by rising edge only: a registered step_d; step_pulse = step & ~step_d.
REQ-017 SHALL take the following transitions from IDLE: start -> RUN and cycle_cnt cleared to 0; else step_pulse -> STEP and cycle_cnt cleared to 0; else stay in IDLE.
REQ-018 SHALL take the following transitions from RUN, in priority order: wb_ir[15:11]==`HALT -> HALTED; stop -> PAUSE; breakpoint match -> PAUSE with bp_hit set; else stay in RUN.
REQ-019 SHALL take the following transitions from STEP: wb_ir[15:11]==`HALT -> HALTED; else always -> PAUSE after exactly one cycle, so state=1 for exactly one cycle per step_pulse.
REQ-020 SHALL define breakpoint match as bp_en & (i_addr==bp_addr) & ~bp_skip, evaluated only in RUN.
REQ-021 SHALL take the following transitions from PAUSE, in priority order: stop holds PAUSE; start -> RUN; step_pulse -> STEP; on leaving PAUSE, bp_hit cleared and bp_skip set.
REQ-022 SHALL clear bp_skip after the first cycle with state=1 following its set; this lets resume execute the breakpointed fetch once without re-triggering.
REQ-023 SHALL leave HALTED only via reset; start, stop and step are ignored there.
REQ-024 SHALL increment cycle_cnt by 1 on every clock edge where state=1, wrapping 16'hFFFF -> 16'h0000.
REQ-025 SHALL hold cycle_cnt in PAUSE and HALTED.
REQ-026 SHALL apply HALT detection in RUN and STEP irrespective of stop/bp, with HALT winning over both in the same cycle.
REQ-027 SHALL ignore a step_pulse in RUN; it is not queued.
REQ-028 SHALL resolve simultaneous start and step_pulse in IDLE or PAUSE to RUN.

Reset
REQ-029 SHALL on reset low, asynchronously force run_state=IDLE, state=0, cycle_cnt=0, bp_hit=0, bp_skip=0, step_d=0.
REQ-030 SHALL when reset is asserted mid-RUN, drop state to 0 immediately without waiting for a clock edge.
REQ-031 SHALL after reset release, remain in IDLE until start or step_pulse.

Verification
REQ-032 SHALL cover this scenario: reset, start=1 for 10 cycles, wb_ir opcode never HALT -> state=1 throughout and cycle_cnt=10; then stop=1 -> run_state=3, cycle_cnt held at 10.
REQ-033 SHALL cover this scenario: from PAUSE, step held high for 5 cycles -> exactly one state=1 cycle, cycle_cnt +1, run_state returns to 3.
REQ-034 SHALL cover this scenario: bp_en=1, bp_addr=8'h05, run with i_addr counting 0,1,2,... -> state=0 combinationally in the cycle i_addr=8'h05, run_state=3, bp_hit=1; then start -> i_addr 05 executes once, bp_hit=0, run continues past 8'h05.
REQ-035 SHALL cover this scenario: during RUN, wb_ir[15:11]=`HALT together with stop=1 -> run_state=4, state=0; subsequent start/step produce no change until reset.
REQ-036 SHALL cover this scenario: preload cycle_cnt to 16'hFFFE via run, run 3 more exec cycles -> cycle_cnt=16'h0001.
REQ-037 SHALL cover this scenario: reset pulsed low between clock edges during RUN -> all outputs at reset values before the next rising edge.
